// File: rtl/arb_pkg.sv
// Shared types and helpers for the host round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Host id width; a single host still needs one bit to index it.
  function automatic int id_width(input int nr_hosts);
    return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// Owner-id FIFO: records which host issued each granted-but-unanswered transaction.
module arb_id_fifo #(
  parameter int Depth = 2,
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/host_rr_arbiter.sv
// Round-robin arbiter funnelling several request/grant hosts onto one device port,
// routing in-order responses back to the host that issued each transaction.
//
// state  | meaning
// ARB    | round-robin pick among requesting hosts
// LOCKED | device stalled the pick; hold locked_id until granted or dropped
module host_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NrHosts        = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    host_req_i    [NrHosts],
  output logic                    host_gnt_o    [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
  input  logic                    host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
  output logic                    host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
  output logic                    host_err_o    [NrHosts],

  output logic                    dev_req_o,
  input  logic                    dev_gnt_i,
  output logic [AddressWidth-1:0] dev_addr_o,
  output logic                    dev_we_o,
  output logic [DataWidth/8-1:0]  dev_be_o,
  output logic [DataWidth-1:0]    dev_wdata_o,
  input  logic                    dev_rvalid_i,
  input  logic [DataWidth-1:0]    dev_rdata_i,
  input  logic                    dev_err_i
);

  localparam int IdW = id_width(NrHosts);

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] locked_q, locked_d;
  logic [IdW-1:0] last_granted;
  logic [IdW-1:0] rr_id;
  logic           rr_valid;
  logic [IdW-1:0] sel_id;
  logic           dev_req;
  logic           fire;
  logic           pop;
  logic [IdW-1:0] head_id;
  logic           fifo_full;
  logic           fifo_empty;

  always_comb begin
    int idx;
    idx      = 0;
    rr_valid = 1'b0;
    rr_id    = '0;
    for (int k = 1; k <= NrHosts; k++) begin
      idx = (int'(last_granted) + k) % NrHosts;
      if (!rr_valid && host_req_i[idx]) begin
        rr_valid = 1'b1;
        rr_id    = IdW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    sel_id   = rr_id;
    dev_req  = 1'b0;
    case (state_q)
      LOCKED: begin
        sel_id  = locked_q;
        dev_req = host_req_i[locked_q];
        if (!host_req_i[locked_q] || dev_gnt_i) state_d = ARB;
      end
      default: begin
        sel_id  = rr_id;
        dev_req = rr_valid && !fifo_full;
        if (dev_req && !dev_gnt_i) begin
          state_d  = LOCKED;
          locked_d = rr_id;
        end
      end
    endcase
    // Combinational request path must stay quiet while reset is asserted.
    dev_req = dev_req && rst_ni;
  end

  assign fire        = dev_req && dev_gnt_i;
  assign pop         = dev_rvalid_i && !fifo_empty;
  assign dev_req_o   = dev_req;
  assign dev_addr_o  = dev_req ? host_addr_i[sel_id]  : '0;
  assign dev_we_o    = dev_req ? host_we_i[sel_id]    : 1'b0;
  assign dev_be_o    = dev_req ? host_be_i[sel_id]    : '0;
  assign dev_wdata_o = dev_req ? host_wdata_i[sel_id] : '0;

  always_comb begin
    for (int i = 0; i < NrHosts; i++) begin
      host_gnt_o[i]    = fire && (sel_id == IdW'(i));
      host_rvalid_o[i] = pop && (head_id == IdW'(i));
      host_err_o[i]    = pop && (head_id == IdW'(i)) && dev_err_i;
      host_rdata_o[i]  = dev_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB;
      locked_q     <= '0;
      last_granted <= IdW'(NrHosts - 1);
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      if (fire) last_granted <= sel_id;
    end
  end

  arb_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fire),
    .data_i  (sel_id),
    .pop_i   (pop),
    .head_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(dev_rvalid_i && fifo_empty))
        else $warning("host_rr_arbiter: dev_rvalid_i with no outstanding transaction");
    end
  end

endmodule

// File: tb/tb_host_rr_arbiter.sv
// Directed bench for host_rr_arbiter with hand-computed expectations.
module tb_host_rr_arbiter;

  localparam int NH = 2;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          host_req_i    [NH];
  logic          host_gnt_o    [NH];
  logic [AW-1:0] host_addr_i   [NH];
  logic          host_we_i     [NH];
  logic [DW/8-1:0] host_be_i   [NH];
  logic [DW-1:0] host_wdata_i  [NH];
  logic          host_rvalid_o [NH];
  logic [DW-1:0] host_rdata_o  [NH];
  logic          host_err_o    [NH];
  logic          dev_req_o;
  logic          dev_gnt_i;
  logic [AW-1:0] dev_addr_o;
  logic          dev_we_o;
  logic [DW/8-1:0] dev_be_o;
  logic [DW-1:0] dev_wdata_o;
  logic          dev_rvalid_i;
  logic [DW-1:0] dev_rdata_i;
  logic          dev_err_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  host_rr_arbiter #(
    .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
    .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .dev_req_o(dev_req_o), .dev_gnt_i(dev_gnt_i), .dev_addr_o(dev_addr_o),
    .dev_we_o(dev_we_o), .dev_be_o(dev_be_o), .dev_wdata_o(dev_wdata_o),
    .dev_rvalid_i(dev_rvalid_i), .dev_rdata_i(dev_rdata_i), .dev_err_i(dev_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    chk({tag, "_gnt0"}, host_gnt_o[0], g0);
    chk({tag, "_gnt1"}, host_gnt_o[1], g1);
  endtask

  task automatic chk_rv(input string tag, input logic r0, input logic r1);
    chk({tag, "_rv0"}, host_rvalid_o[0], r0);
    chk({tag, "_rv1"}, host_rvalid_o[1], r1);
  endtask

  initial begin
    rst_ni       = 1'b0;
    dev_gnt_i    = 1'b1;
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;
    host_addr_i[0]  = 32'h0000_1000;
    host_addr_i[1]  = 32'h0000_2000;
    host_we_i[0]    = 1'b1;
    host_we_i[1]    = 1'b0;
    host_be_i[0]    = 4'h3;
    host_be_i[1]    = 4'hc;
    host_wdata_i[0] = 32'h1111_0000;
    host_wdata_i[1] = 32'h2222_0000;
    host_req_i[0]   = 1'b1;
    host_req_i[1]   = 1'b1;

    // Reset: requests and grant present, nothing may leak out.
    repeat (2) @(posedge clk_i);
    #1;
    dev_rvalid_i = 1'b1;
    #1;
    chk("rst_dev_req", dev_req_o, 1'b0);
    chk("rst_addr", dev_addr_o, 32'h0);
    chk_gnt("rst", 1'b0, 1'b0);
    chk_rv("rst", 1'b0, 1'b0);
    dev_rvalid_i  = 1'b0;
    host_req_i[0] = 1'b0;
    host_req_i[1] = 1'b0;
    rst_ni        = 1'b1;

    // Single read from host1.
    tick();
    host_addr_i[1] = 32'h0010_0004;
    host_req_i[1]  = 1'b1;
    #1;
    chk("s1_dev_req", dev_req_o, 1'b1);
    chk("s1_addr", dev_addr_o, 32'h0010_0004);
    chk("s1_we", dev_we_o, 1'b0);
    chk("s1_be", dev_be_o, 4'hc);
    chk_gnt("s1", 1'b0, 1'b1);
    tick();
    host_req_i[1] = 1'b0;
    dev_rvalid_i  = 1'b1;
    dev_rdata_i   = 32'hDEAD_BEEF;
    #1;
    chk_rv("s1", 1'b0, 1'b1);
    chk("s1_rdata1", host_rdata_o[1], 32'hDEAD_BEEF);
    chk("s1_err1", host_err_o[1], 1'b0);
    chk("s1_idle_req", dev_req_o, 1'b0);
    host_addr_i[1] = 32'h0000_2000;

    // Continuous requests: grants alternate 0,1,0,1, responses one cycle later.
    for (int k = 0; k < 4; k++) begin
      tick();
      host_req_i[0] = 1'b1;
      host_req_i[1] = 1'b1;
      dev_rvalid_i  = (k > 0);
      dev_rdata_i   = 32'hA000_0000 + k;
      dev_err_i     = (k == 2);
      #1;
      chk($sformatf("rr%0d_gnt0", k), host_gnt_o[0], (k % 2) == 0);
      chk($sformatf("rr%0d_gnt1", k), host_gnt_o[1], (k % 2) == 1);
      chk($sformatf("rr%0d_addr", k), dev_addr_o, (k % 2) ? 32'h0000_2000 : 32'h0000_1000);
      chk($sformatf("rr%0d_rv0", k), host_rvalid_o[0], (k > 0) && ((k - 1) % 2 == 0));
      chk($sformatf("rr%0d_rv1", k), host_rvalid_o[1], (k > 0) && ((k - 1) % 2 == 1));
      chk($sformatf("rr%0d_err1", k), host_err_o[1], k == 2);
    end
    tick();
    host_req_i[0] = 1'b0;
    host_req_i[1] = 1'b0;
    dev_err_i     = 1'b0;
    #1;
    chk_rv("rr_tail", 1'b0, 1'b1);

    // Prime last_granted = 0 with a lone host0 transaction.
    tick();
    dev_rvalid_i  = 1'b0;
    host_req_i[0] = 1'b1;
    #1;
    chk_gnt("prime", 1'b1, 1'b0);
    tick();
    host_req_i[0] = 1'b0;
    dev_rvalid_i  = 1'b1;
    #1;
    chk_rv("prime", 1'b1, 1'b0);

    // Stall: host0 picked, then host1 joins; lock keeps host0 despite round-robin preferring host1.
    for (int c = 1; c <= 3; c++) begin
      tick();
      dev_rvalid_i  = 1'b0;
      dev_gnt_i     = 1'b0;
      host_req_i[0] = 1'b1;
      host_req_i[1] = (c > 1);
      #1;
      chk($sformatf("lk%0d_req", c), dev_req_o, 1'b1);
      chk($sformatf("lk%0d_addr", c), dev_addr_o, 32'h0000_1000);
      chk_gnt($sformatf("lk%0d", c), 1'b0, 1'b0);
    end
    tick();
    dev_gnt_i = 1'b1;
    #1;
    chk_gnt("lk4", 1'b1, 1'b0);
    chk("lk4_wdata", dev_wdata_o, 32'h1111_0000);
    tick();
    dev_rvalid_i = 1'b1;
    #1;
    chk_gnt("lk5", 1'b0, 1'b1);
    chk("lk5_addr", dev_addr_o, 32'h0000_2000);
    chk_rv("lk5", 1'b1, 1'b0);
    tick();
    host_req_i[0] = 1'b0;
    host_req_i[1] = 1'b0;
    #1;
    chk_rv("lk6", 1'b0, 1'b1);

    // Outstanding limit: two grants fill the FIFO (last_granted=1, so 0 then 1).
    tick();
    dev_rvalid_i  = 1'b0;
    host_req_i[0] = 1'b1;
    host_req_i[1] = 1'b1;
    #1;
    chk_gnt("mo_a", 1'b1, 1'b0);
    tick();
    #1;
    chk_gnt("mo_b", 1'b0, 1'b1);
    tick();
    #1;
    chk("mo_full_req", dev_req_o, 1'b0);
    chk_gnt("mo_full", 1'b0, 1'b0);
    tick();
    dev_rvalid_i = 1'b1;
    #1;
    chk("mo_pop_req", dev_req_o, 1'b0);
    chk_rv("mo_pop", 1'b1, 1'b0);
    tick();
    dev_rvalid_i = 1'b0;
    #1;
    chk("mo_after_req", dev_req_o, 1'b1);
    chk_gnt("mo_after", 1'b1, 1'b0);
    tick();
    host_req_i[0] = 1'b0;
    host_req_i[1] = 1'b0;
    dev_rvalid_i  = 1'b1;
    #1;
    chk_rv("mo_drain1", 1'b0, 1'b1);
    tick();
    #1;
    chk_rv("mo_drain0", 1'b1, 1'b0);

    // Stray response with nothing outstanding.
    tick();
    #1;
    chk_rv("stray", 1'b0, 1'b0);
    chk("stray_err0", host_err_o[0], 1'b0);

    // Reset with two outstanding (host1 then host0, last_granted ends at 0).
    tick();
    dev_rvalid_i  = 1'b0;
    host_req_i[0] = 1'b1;
    host_req_i[1] = 1'b1;
    #1;
    chk_gnt("pr_a", 1'b0, 1'b1);
    tick();
    #1;
    chk_gnt("pr_b", 1'b1, 1'b0);
    tick();
    host_req_i[0] = 1'b0;
    host_req_i[1] = 1'b0;
    rst_ni        = 1'b0;
    #2;
    chk("pr_rst_req", dev_req_o, 1'b0);
    tick();
    rst_ni       = 1'b1;
    dev_rvalid_i = 1'b1;
    #1;
    chk_rv("pr_flushed", 1'b0, 1'b0);
    tick();
    dev_rvalid_i  = 1'b0;
    host_req_i[0] = 1'b1;
    host_req_i[1] = 1'b1;
    #1;
    chk_gnt("pr_first", 1'b1, 1'b0);
    tick();
    host_req_i[0] = 1'b0;
    host_req_i[1] = 1'b0;
    dev_rvalid_i  = 1'b1;
    #1;
    chk_rv("pr_resp", 1'b1, 1'b0);
    tick();
    dev_rvalid_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_rr_arbiter.md
HOST_RR_ARBITER -- requirements
Module: host_rr_arbiter

Interface
REQ-001 SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 SHALL have parameter DataWidth, default 32, data bus width.
REQ-003 SHALL have parameter AddressWidth, default 32, address bus width.
REQ-004 SHALL have parameter MaxOutstanding, default 2, number of granted-but-unanswered transactions allowed (1..4).
REQ-005 SHALL have one clock and asynchronous active-low reset: clk_i input 1, the only clock; rst_ni input 1, async active-low reset.
REQ-006 SHALL have the following host ports, one element per host, in unpacked arrays [NrHosts]:
- host_req_i  input  1  request.
- host_gnt_o  output  1  grant.
- host_addr_i  input  AddressWidth  address.
- host_we_i  input  1  write enable.
- host_be_i  input  DataWidth/8  byte enables.
- host_wdata_i  input  DataWidth  write data.
- host_rvalid_o  output  1  response valid.
- host_rdata_o  output  DataWidth  read data.
- host_err_o  output  1  response error.
REQ-007 SHALL have the following device ports:
- dev_req_o  output  1  request.
- dev_gnt_i  input  1  grant.
- dev_addr_o  output  AddressWidth  address.
- dev_we_o  output  1  write enable.
- dev_be_o  output  DataWidth/8  byte enables.
- dev_wdata_o  output  DataWidth  write data.
- dev_rvalid_i  input  1  response valid.
- dev_rdata_i  input  DataWidth  read data.
- dev_err_i  input  1  response error.

Function
REQ-008 SHALL use a request/grant protocol: an address phase completes in the cycle where req and gnt are both high; the response is one dev_rvalid_i pulse per granted transaction, in grant order, at least one cycle after the grant.
REQ-009 SHALL select the winning host round-robin: search starts at (last_granted+1) mod NrHosts and picks the first host with host_req_i high.
REQ-010 SHALL drive dev_req_o high when at least one host requests, no lock is pending, and outstanding count < MaxOutstanding.
REQ-011 SHALL drive dev_req_o high, while a lock is pending, exactly when the locked host requests.
REQ-012 SHALL drive dev_addr_o/we/be/wdata combinationally from the selected host, and drive '0 when dev_req_o is low.
REQ-013 SHALL assert host_gnt_o[i] combinationally iff dev_req_o && dev_gnt_i && selected==i; all other grants SHALL be low.
REQ-014 SHALL lock the selection (state LOCKED, holding locked_id) when dev_req_o is high and dev_gnt_i is low; selection SHALL stay on locked_id until its grant, then return to state ARB; if the locked host drops req, SHALL return to ARB.
REQ-015 SHALL, on each grant, update last_granted to the winner and push the winner id into an owner FIFO of depth MaxOutstanding.
REQ-016 SHALL, on dev_rvalid_i, pop the FIFO head and assert host_rvalid_o[head] and host_err_o[head] = dev_err_i for that cycle only.
REQ-017 SHALL drive host_rdata_o[i] = dev_rdata_i for all hosts.
REQ-018 SHALL keep the outstanding count unchanged when a push and a pop happen in the same cycle.
REQ-019 SHALL, when the FIFO is full, hold dev_req_o low even if dev_rvalid_i pops the FIFO in that cycle; the request is issued the following cycle.
REQ-020 SHALL ignore dev_rvalid_i while the FIFO is empty (no host_rvalid_o) and flag it with a simulation assertion.
REQ-021 SHALL, when NrHosts requests are continuous, grant each host exactly once per NrHosts grants.

Reset
REQ-022 SHALL reset asynchronously on rst_ni low:
- state ARB, lock cleared;
- last_granted = NrHosts-1, so host 0 wins first;
- FIFO empty, count 0.
REQ-023 SHALL hold all host_gnt_o, host_rvalid_o, host_err_o and dev_req_o low during reset; responses outstanding at reset SHALL be discarded.

Structure
REQ-024 SHALL place the id width constant (IdW = $clog2(NrHosts), minimum 1) and the arbiter state enum {ARB, LOCKED} in a shared package arb_pkg.
REQ-025 SHALL implement the owner FIFO as sub-module arb_id_fifo, parameterised by depth and width, with push/pop/full/empty/head.

Verification
REQ-026 SHALL cover these directed scenarios:
- Reset release, host1 alone requests addr 0x100004, dev_gnt_i=1 -> dev_addr_o=0x100004; host_gnt_o[1]=1 same cycle; rvalid next cycle with rdata 0xDEADBEEF -> host_rvalid_o[1]=1, host_rdata_o[1]=0xDEADBEEF.
- Both hosts request continuously, gnt always 1, rvalid one cycle later -> grants alternate 0,1,0,1; each host's rvalid lands on it.
- dev_gnt_i low for 3 cycles while host0 selected, host1 also requesting -> dev_addr_o stays on host0 for all 3 cycles; host0 granted on cycle 4, host1 next.
- MaxOutstanding=2, responses withheld -> after 2 grants dev_req_o=0; one rvalid -> dev_req_o=1 on the following cycle.
- Stray dev_rvalid_i with empty FIFO -> no host_rvalid_o and the assertion fires.
- rst_ni pulsed low with 2 outstanding -> FIFO empty, next grant goes to host 0, later dev_rvalid_i is not routed to any host.
